// File: rtl/radix4_operand_gather_pkg.sv
// Shared constants and twiddle helpers for the radix-4 operand gather block.
// Twiddles are generated at elaboration from the modulus and its generator.
package radix4_operand_gather_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned N_POINTS = 256;
  localparam int unsigned GRP_BITS = 6;
  localparam int unsigned Q        = 7681;
  localparam int unsigned GEN      = 17;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  function automatic int unsigned mod_pow(int unsigned base, int unsigned e);
    int unsigned r = 1;
    int unsigned b = base % Q;
    for (int unsigned x = e; x != 0; x = x >> 1) begin
      if (x[0]) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return r;
  endfunction

  // n-th root of unity for NTT, its inverse for INTT
  function automatic int unsigned root_of(logic mode, int unsigned n);
    int unsigned w = mod_pow(GEN, (Q - 1) / n);
    return (mode == MODE_INTT) ? mod_pow(w, n - 1) : w;
  endfunction

endpackage

// File: rtl/radix4_operand_gather_if.sv
// Coefficient input stream and operand bundle output stream of the gather block.
interface radix4_operand_gather_if
  import radix4_operand_gather_pkg::*;
#(
  parameter int unsigned width = WIDTH
);
  logic             flush;
  logic             mode_in;
  logic [width-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] out_x1, out_x2, out_x3, out_x4;
  logic [width-1:0] out_tw2, out_tw3, out_tw4;
  logic             out_select;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output flush, mode_in, in_data, in_valid, out_ready,
    input  in_ready, out_x1, out_x2, out_x3, out_x4,
    input  out_tw2, out_tw3, out_tw4, out_select, out_last, out_valid
  );

  modport slave (
    input  flush, mode_in, in_data, in_valid, out_ready,
    output in_ready, out_x1, out_x2, out_x3, out_x4,
    output out_tw2, out_tw3, out_tw4, out_select, out_last, out_valid
  );
endinterface

// File: rtl/radix4_operand_gather_twiddle_rom.sv
// Two-table twiddle ROM (NTT / INTT), entry g = {w^3g, w^2g, w^g} mod q, registered read.
module radix4_operand_gather_twiddle_rom
  import radix4_operand_gather_pkg::*;
#(
  parameter int unsigned width    = WIDTH,
  parameter int unsigned n_points = N_POINTS,
  parameter int unsigned grp_bits = GRP_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [grp_bits-1:0] addr,
  output logic [width-1:0]    tw2,
  output logic [width-1:0]    tw3,
  output logic [width-1:0]    tw4
);
  localparam int unsigned G = n_points / 4;

  logic [3*width-1:0] tbl [2*G];

  for (genvar m = 0; m < 2; m++) begin : g_tbl
    for (genvar g = 0; g < G; g++) begin : g_ent
      localparam int unsigned W1 = mod_pow(root_of(m == 1, n_points), g);
      localparam int unsigned W2 = mod_pow(root_of(m == 1, n_points), 2 * g);
      localparam int unsigned W3 = mod_pow(root_of(m == 1, n_points), 3 * g);
      assign tbl[m*G+g] = {width'(W3), width'(W2), width'(W1)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {tw4, tw3, tw2} <= '0;
    end else if (en) begin
      {tw4, tw3, tw2} <= tbl[{mode, addr}];
    end
  end
endmodule

// File: rtl/radix4_operand_gather.sv
// Gathers four serial coefficients plus three twiddles into a bundle for the radix-4 butterfly,
// with a collect stage feeding a hold stage so the next group can fill while one waits.
module radix4_operand_gather
  import radix4_operand_gather_pkg::*;
#(
  parameter int unsigned width    = WIDTH,
  parameter int unsigned n_points = N_POINTS,
  parameter int unsigned grp_bits = GRP_BITS
) (
  input logic                    clk,
  input logic                    rst_n,
  radix4_operand_gather_if.slave bus
);
  localparam logic [grp_bits-1:0] LAST_GRP = grp_bits'(n_points / 4 - 1);

  logic [1:0]          lane_cnt;
  logic [width-1:0]    lane [4];
  logic                coll_full;
  logic                coll_sel;
  logic [grp_bits-1:0] grp_cnt;
  logic                mode_q;
  logic                rdy_en;
  logic [width-1:0]    hold_x [4];
  logic [width-1:0]    hold_tw2, hold_tw3, hold_tw4;
  logic                hold_sel, hold_last, hold_valid;
  logic [width-1:0]    rom_tw2, rom_tw3, rom_tw4;

  logic                stall_c, ready_c, accept_c, xfer_c, lane0_c, rom_mode_c;
  logic [grp_bits-1:0] grp_c;

  // A beat accepted while collect is full always coincides with a transfer,
  // so it belongs to the group after grp_cnt.
  always_comb begin
    stall_c    = 1'b0;
    ready_c    = 1'b0;
    accept_c   = 1'b0;
    xfer_c     = 1'b0;
    lane0_c    = 1'b0;
    grp_c      = grp_cnt;
    rom_mode_c = mode_q;
    stall_c    = coll_full && hold_valid && !bus.out_ready;
    ready_c    = rdy_en && !stall_c;
    accept_c   = bus.in_valid && ready_c && !bus.flush;
    xfer_c     = coll_full && (!hold_valid || bus.out_ready) && !bus.flush;
    lane0_c    = accept_c && (lane_cnt == 2'd0);
    if (coll_full) grp_c = grp_cnt + grp_bits'(1);
    if (grp_c == '0) rom_mode_c = bus.mode_in;
  end

  // ROM output register doubles as the collect-stage twiddle storage
  radix4_operand_gather_twiddle_rom #(
    .width(width), .n_points(n_points), .grp_bits(grp_bits)
  ) u_rom (
    .clk(clk), .rst_n(rst_n), .en(lane0_c), .mode(rom_mode_c), .addr(grp_c),
    .tw2(rom_tw2), .tw3(rom_tw3), .tw4(rom_tw4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      lane_cnt  <= '0;
      coll_full <= 1'b0;
      coll_sel  <= MODE_NTT;
      grp_cnt   <= '0;
      mode_q    <= MODE_NTT;
      for (int i = 0; i < 4; i++) lane[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (bus.flush) begin
        lane_cnt  <= '0;
        coll_full <= 1'b0;
        grp_cnt   <= '0;
      end else begin
        if (accept_c) begin
          lane[lane_cnt] <= bus.in_data;
          lane_cnt       <= lane_cnt + 2'd1;
          if (lane0_c) coll_sel <= rom_mode_c;
          if (lane0_c && grp_c == '0) mode_q <= bus.mode_in;
        end
        if (xfer_c) grp_cnt <= grp_cnt + grp_bits'(1);
        if (accept_c && lane_cnt == 2'd3) coll_full <= 1'b1;
        else if (xfer_c) coll_full <= 1'b0;
      end
    end
  end

  // Hold stage: reload on transfer, otherwise drop once the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_sel   <= 1'b0;
      hold_last  <= 1'b0;
      hold_tw2   <= '0;
      hold_tw3   <= '0;
      hold_tw4   <= '0;
      for (int i = 0; i < 4; i++) hold_x[i] <= '0;
    end else if (xfer_c) begin
      hold_valid <= 1'b1;
      hold_sel   <= coll_sel;
      hold_last  <= (grp_cnt == LAST_GRP);
      hold_tw2   <= rom_tw2;
      hold_tw3   <= rom_tw3;
      hold_tw4   <= rom_tw4;
      for (int i = 0; i < 4; i++) hold_x[i] <= lane[i];
    end else if (bus.out_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.out_x1     = hold_x[0];
  assign bus.out_x2     = hold_x[1];
  assign bus.out_x3     = hold_x[2];
  assign bus.out_x4     = hold_x[3];
  assign bus.out_tw2    = hold_tw2;
  assign bus.out_tw3    = hold_tw3;
  assign bus.out_tw4    = hold_tw4;
  assign bus.out_select = hold_sel;
  assign bus.out_last   = hold_last;
  assign bus.out_valid  = hold_valid;
endmodule

// File: tb/tb_radix4_operand_gather.sv
// Directed bench for radix4_operand_gather with a 16-point frame (4 groups per frame).
module tb_radix4_operand_gather;
  localparam int unsigned W  = 16;
  localparam int unsigned NP = 16;
  localparam int unsigned GB = 2;
  localparam int unsigned BW = 2 + 7 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  radix4_operand_gather_if #(.width(W)) bus ();

  radix4_operand_gather #(.width(W), .n_points(NP), .grp_bits(GB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic int unsigned npow(int unsigned b, int unsigned e);
    int unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % 7681;
    return r;
  endfunction

  // {tw2, tw3, tw4} = {w^g, w^2g, w^3g}; w = 17^(7680/16), inverse for INTT
  function automatic logic [3*W-1:0] model_tw(bit sel, int unsigned g);
    int unsigned w = npow(17, 480);
    if (sel) w = npow(w, 15);
    return {16'(npow(w, g)), 16'(npow(w, 2 * g)), 16'(npow(w, 3 * g))};
  endfunction

  function automatic logic [BW-1:0] exp_bundle(int unsigned first, bit sel, int unsigned g, bit last);
    return {last, sel, 16'(first), 16'(first + 1), 16'(first + 2), 16'(first + 3), model_tw(sel, g)};
  endfunction

  function automatic logic [BW-1:0] bundle_now();
    return {bus.out_last, bus.out_select, bus.out_x1, bus.out_x2, bus.out_x3, bus.out_x4,
            bus.out_tw2, bus.out_tw3, bus.out_tw4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.mode_in = 1'b0;
    bus.out_ready = 1'b0; bus.in_data = '0;
    #20;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h00aa; bus.flush = 1'b0;
    bus.mode_in = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00)
        $display("FAIL reset_hold%0d: valid/ready %b, expected 00", i, {bus.out_valid, bus.in_ready});
      else passed++;
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_release: in_ready %b, expected 0", bus.in_ready);
    else passed++;
    step();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL reset_ready_rise: valid/ready %b, expected 01", {bus.out_valid, bus.in_ready});
    else passed++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [BW-1:0] exp;
    bit exp_v;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = (i <= 8);
      bus.in_data  = 16'(i);
      step();
      exp_v = (i == 5 || i == 9);
      exp   = (i == 5) ? exp_bundle(1, 0, 0, 0) : exp_bundle(5, 0, 1, 0);
      total++;
      if (bus.out_valid !== exp_v || (exp_v && bundle_now() !== exp))
        $display("FAIL stream_cyc%0d: valid %b bundle %h, expected valid %b bundle %h",
                 i, bus.out_valid, bundle_now(), exp_v, exp);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_data = 16'(i);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_beat%0d: in_ready %b, expected 1", i, bus.in_ready);
      else passed++;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 16'd9;
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bundle_now() !== exp_bundle(1, 0, 0, 0))
        $display("FAIL bp_stall%0d: ready %b valid %b bundle %h, expected ready 0 valid 1 bundle %h",
                 k, bus.in_ready, bus.out_valid, bundle_now(), exp_bundle(1, 0, 0, 0));
      else passed++;
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready %b, expected 1", bus.in_ready);
    else passed++;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bundle_now() !== exp_bundle(5, 0, 1, 0))
      $display("FAIL bp_second: valid %b bundle %h, expected valid 1 bundle %h",
               bus.out_valid, bundle_now(), exp_bundle(5, 0, 1, 0));
    else passed++;
    for (int i = 10; i <= 12; i++) begin
      bus.in_data = 16'(i);
      step();
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL bp_gap_beat%0d: valid %b, expected 0", i, bus.out_valid);
      else passed++;
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bundle_now() !== exp_bundle(9, 0, 2, 0))
      $display("FAIL bp_third: valid %b bundle %h, expected valid 1 bundle %h",
               bus.out_valid, bundle_now(), exp_bundle(9, 0, 2, 0));
    else passed++;
  endtask

  task automatic test_frame_wrap();
    logic [BW-1:0] exp;
    bit exp_v;
    int unsigned g;
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      bus.in_valid = (cyc <= 20);
      bus.in_data  = 16'(cyc);
      step();
      exp_v = (cyc >= 5 && cyc <= 21 && cyc % 4 == 1);
      g     = exp_v ? ((cyc - 5) / 4) % 4 : 0;
      exp   = exp_bundle(cyc - 4, 0, g, g == 3);
      total++;
      if (bus.out_valid !== exp_v || (exp_v && bundle_now() !== exp))
        $display("FAIL wrap_cyc%0d: valid %b bundle %h, expected valid %b bundle %h",
                 cyc, bus.out_valid, bundle_now(), exp_v, exp);
      else passed++;
    end
  endtask

  task automatic test_mode_latch();
    logic [BW-1:0] exp;
    bit exp_v;
    int unsigned g;
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      bus.in_valid = (cyc <= 20);
      bus.in_data  = 16'(cyc);
      bus.mode_in  = (cyc < 6);
      step();
      exp_v = (cyc >= 5 && cyc <= 21 && cyc % 4 == 1);
      g     = exp_v ? ((cyc - 5) / 4) % 4 : 0;
      exp   = exp_bundle(cyc - 4, cyc <= 17, g, g == 3);
      total++;
      if (bus.out_valid !== exp_v || (exp_v && bundle_now() !== exp))
        $display("FAIL mode_cyc%0d: valid %b bundle %h, expected valid %b bundle %h",
                 cyc, bus.out_valid, bundle_now(), exp_v, exp);
      else passed++;
    end
    bus.mode_in = 1'b0;
  endtask

  task automatic test_flush();
    logic [BW-1:0] exp;
    bit exp_v;
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      bus.flush    = (cyc == 7);
      bus.in_valid = (cyc <= 11);
      bus.in_data  = (cyc <= 6) ? 16'(cyc) : (cyc == 7) ? 16'd99 : 16'(cyc - 1);
      if (cyc == 7) begin
        #1;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL flush_ready: in_ready %b, expected 1", bus.in_ready);
        else passed++;
      end
      step();
      exp_v = (cyc == 5 || cyc == 12);
      exp   = (cyc == 5) ? exp_bundle(1, 0, 0, 0) : exp_bundle(7, 0, 0, 0);
      total++;
      if (bus.out_valid !== exp_v || (exp_v && bundle_now() !== exp))
        $display("FAIL flush_cyc%0d: valid %b bundle %h, expected valid %b bundle %h",
                 cyc, bus.out_valid, bundle_now(), exp_v, exp);
      else passed++;
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [BW-1:0] exp;
    bit exp_v;
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.in_data = 16'(i);
      step();
    end
    total++;
    if (bus.out_valid !== 1'b1) $display("FAIL areset_pending: valid %b, expected 1", bus.out_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00)
      $display("FAIL areset_async: valid/ready %b, expected 00", {bus.out_valid, bus.in_ready});
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      bus.in_valid = (cyc <= 4);
      bus.in_data  = 16'(cyc + 6);
      step();
      exp_v = (cyc == 5);
      exp   = exp_bundle(7, 0, 0, 0);
      total++;
      if (bus.out_valid !== exp_v || (exp_v && bundle_now() !== exp))
        $display("FAIL areset_cyc%0d: valid %b bundle %h, expected valid %b bundle %h",
                 cyc, bus.out_valid, bundle_now(), exp_v, exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_frame_wrap();
    test_mode_latch();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
